// File: rtl/tree_argmax_pkg.sv
// Shared constants and elaboration helpers for the pipelined argmax tree.
package tree_argmax_pkg;

    localparam int PerfCntWidth = 32;

    function automatic int tree_levels(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Heap layout: root is 0, children of node h are 2h+1 and 2h+2.
    function automatic int heap_idx(input int level, input int l);
        return (1 << level) - 1 + l;
    endfunction

endpackage

// File: rtl/tree_argmax_node.sv
// Combinational two-child argmax merge; ties resolve to the left (lower index) child.
module tree_argmax_node #(
    parameter int DataWidth = 32,
    parameter int IdxWidth  = 1
) (
    input  logic                 left_part,
    input  logic [DataWidth-1:0] left_data,
    input  logic [IdxWidth-1:0]  left_idx,
    input  logic                 right_part,
    input  logic [DataWidth-1:0] right_data,
    input  logic [IdxWidth-1:0]  right_idx,
    output logic                 merged_part,
    output logic [DataWidth-1:0] merged_data,
    output logic [IdxWidth-1:0]  merged_idx
);

    always_comb begin
        merged_part = left_part | right_part;
        merged_data = '0;
        merged_idx  = '0;
        if (left_part && (!right_part || left_data >= right_data)) begin
            merged_data = left_data;
            merged_idx  = left_idx;
        end else if (right_part) begin
            merged_data = right_data;
            merged_idx  = right_idx;
        end
    end

endmodule

// File: rtl/tree_argmax_pipe.sv
// Pipelined binary-tree argmax, one register stage per tree level, global stall enable.
// Optional macro TREE_ARGMAX_PIPE_PERF_CNT_EN adds handshake and stall counters.
module tree_argmax_pipe
    import tree_argmax_pkg::*;
#(
    parameter  int NumIn     = 5,
    parameter  int DataWidth = 32,
    localparam int Levels    = tree_levels(NumIn),
    localparam int IdxWidth  = (NumIn > 1) ? $clog2(NumIn) : 1
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic [NumIn*DataWidth-1:0] in_data_i,
    input  logic [NumIn-1:0]           in_mask_i,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [DataWidth-1:0]       out_data_o,
    output logic [IdxWidth-1:0]        out_idx_o,
    output logic                       out_any_o
`ifdef TREE_ARGMAX_PIPE_PERF_CNT_EN
    ,
    output logic [PerfCntWidth-1:0]    perf_cnt_o,
    output logic [PerfCntWidth-1:0]    perf_stall_o
`endif
);

    localparam int NumLeaves = 1 << Levels;
    localparam int NumNodes  = NumLeaves - 1;

    logic [NumLeaves-1:0] leaf_part;
    logic [DataWidth-1:0] leaf_data [NumLeaves];
    logic [IdxWidth-1:0]  leaf_idx  [NumLeaves];

    logic [NumNodes-1:0]  node_part_q;
    logic [DataWidth-1:0] node_data_q [NumNodes];
    logic [IdxWidth-1:0]  node_idx_q  [NumNodes];

    logic [NumNodes-1:0]  mrg_part;
    logic [DataWidth-1:0] mrg_data [NumNodes];
    logic [IdxWidth-1:0]  mrg_idx  [NumNodes];

    logic [Levels-1:0]    valid_q;
    logic [Levels-1:0]    valid_in;
    logic                 en;

    for (genvar l = 0; l < NumLeaves; l++) begin : g_leaf
        if (l < NumIn) begin : g_real
            assign leaf_part[l] = in_mask_i[l];
            assign leaf_data[l] = in_data_i[l*DataWidth +: DataWidth];
            assign leaf_idx[l]  = IdxWidth'(l);
        end else begin : g_pad
            assign leaf_part[l] = 1'b0;
            assign leaf_data[l] = '0;
            assign leaf_idx[l]  = '0;
        end
    end

    // The deepest stage merges leaves straight from the inputs; others merge the stage below.
    for (genvar k = 0; k < Levels; k++) begin : g_level
        for (genvar l = 0; l < (1 << k); l++) begin : g_node
            localparam int H = heap_idx(k, l);
            if (k == Levels - 1) begin : g_from_leaf
                tree_argmax_node #(.DataWidth(DataWidth), .IdxWidth(IdxWidth)) u_node (
                    .left_part   (leaf_part[2*l]),
                    .left_data   (leaf_data[2*l]),
                    .left_idx    (leaf_idx[2*l]),
                    .right_part  (leaf_part[2*l+1]),
                    .right_data  (leaf_data[2*l+1]),
                    .right_idx   (leaf_idx[2*l+1]),
                    .merged_part (mrg_part[H]),
                    .merged_data (mrg_data[H]),
                    .merged_idx  (mrg_idx[H])
                );
            end else begin : g_from_node
                localparam int C = heap_idx(k + 1, 2 * l);
                tree_argmax_node #(.DataWidth(DataWidth), .IdxWidth(IdxWidth)) u_node (
                    .left_part   (node_part_q[C]),
                    .left_data   (node_data_q[C]),
                    .left_idx    (node_idx_q[C]),
                    .right_part  (node_part_q[C+1]),
                    .right_data  (node_data_q[C+1]),
                    .right_idx   (node_idx_q[C+1]),
                    .merged_part (mrg_part[H]),
                    .merged_data (mrg_data[H]),
                    .merged_idx  (mrg_idx[H])
                );
            end
        end
    end

    assign en = ~valid_q[0] | out_ready_i;

    always_comb begin
        valid_in             = valid_q >> 1;
        valid_in[Levels-1]   = in_valid_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q     <= '0;
            node_part_q <= '0;
            for (int h = 0; h < NumNodes; h++) begin
                node_data_q[h] <= '0;
                node_idx_q[h]  <= '0;
            end
        end else if (en) begin
            valid_q <= valid_in;
            for (int k = 0; k < Levels; k++) begin
                if (valid_in[k]) begin
                    for (int l = 0; l < (1 << k); l++) begin
                        node_part_q[heap_idx(k, l)] <= mrg_part[heap_idx(k, l)];
                        node_data_q[heap_idx(k, l)] <= mrg_data[heap_idx(k, l)];
                        node_idx_q[heap_idx(k, l)]  <= mrg_idx[heap_idx(k, l)];
                    end
                end
            end
        end
    end

    assign in_ready_o  = en;
    assign out_valid_o = valid_q[0];
    assign out_data_o  = node_data_q[0];
    assign out_idx_o   = node_idx_q[0];
    assign out_any_o   = node_part_q[0];

`ifdef TREE_ARGMAX_PIPE_PERF_CNT_EN
    logic [PerfCntWidth-1:0] perf_cnt_q;
    logic [PerfCntWidth-1:0] perf_stall_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            perf_cnt_q   <= '0;
            perf_stall_q <= '0;
        end else if (valid_q[0]) begin
            if (out_ready_i) perf_cnt_q   <= perf_cnt_q + 1'b1;
            else             perf_stall_q <= perf_stall_q + 1'b1;
        end
    end

    assign perf_cnt_o   = perf_cnt_q;
    assign perf_stall_o = perf_stall_q;
`endif

endmodule

// File: tb/tb_tree_argmax_pipe.sv
// Directed bench for tree_argmax_pipe: a NumIn=5 instance and a NumIn=1 instance.
module tb_tree_argmax_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [39:0] in_data = '0;
    logic [4:0]  in_mask = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [7:0]  out_data;
    logic [2:0]  out_idx;
    logic        out_any;

    logic        in1_valid = 1'b0;
    logic        in1_ready;
    logic [7:0]  in1_data = '0;
    logic [0:0]  in1_mask = '0;
    logic        out1_valid;
    logic        out1_ready = 1'b1;
    logic [7:0]  out1_data;
    logic [0:0]  out1_idx;
    logic        out1_any;

`ifdef TREE_ARGMAX_PIPE_PERF_CNT_EN
    logic [31:0] perf_cnt, perf_stall, perf1_cnt, perf1_stall;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    tree_argmax_pipe #(.NumIn(5), .DataWidth(8)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_data_i   (in_data),
        .in_mask_i   (in_mask),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (out_data),
        .out_idx_o   (out_idx),
        .out_any_o   (out_any)
`ifdef TREE_ARGMAX_PIPE_PERF_CNT_EN
        ,
        .perf_cnt_o  (perf_cnt),
        .perf_stall_o(perf_stall)
`endif
    );

    tree_argmax_pipe #(.NumIn(1), .DataWidth(8)) dut1 (
        .clk_i       (clk),
        .rst_i       (rst),
        .in_valid_i  (in1_valid),
        .in_ready_o  (in1_ready),
        .in_data_i   (in1_data),
        .in_mask_i   (in1_mask),
        .out_valid_o (out1_valid),
        .out_ready_i (out1_ready),
        .out_data_o  (out1_data),
        .out_idx_o   (out1_idx),
        .out_any_o   (out1_any)
`ifdef TREE_ARGMAX_PIPE_PERF_CNT_EN
        ,
        .perf_cnt_o  (perf1_cnt),
        .perf_stall_o(perf1_stall)
`endif
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [39:0] pack5(input logic [7:0] a, b, c, d, e);
        return {e, d, c, b, a};
    endfunction

    task automatic test_reset;
        rst = 1'b1;
        tick;
        tick;
        rst = 1'b0;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || out_data !== 8'd0 || out_idx !== 3'd0 || out_any !== 1'b0) begin
            n_err++;
            $display("FAIL reset_outputs: got v=%b d=%h i=%0d a=%b, want v=0 d=00 i=0 a=0",
                     out_valid, out_data, out_idx, out_any);
        end
        n_cmp++;
        if (in_ready !== 1'b1 || in1_ready !== 1'b1 || out1_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_ready: got in_ready=%b in1_ready=%b out1_valid=%b, want 1 1 0",
                     in_ready, in1_ready, out1_valid);
        end
    endtask

    task automatic run_one(input logic [39:0] d, input logic [4:0] m, input logic [7:0] ed,
                           input logic [2:0] ei, input logic ea, input string name);
        in_data  = d;
        in_mask  = m;
        in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        tick;
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL %s_early: out_valid=%b two edges after accept, want 0", name, out_valid);
        end
        tick;
        n_cmp++;
        if (out_valid !== 1'b1 || out_data !== ed || out_idx !== ei || out_any !== ea) begin
            n_err++;
            $display("FAIL %s: got v=%b d=%0d i=%0d a=%b, want v=1 d=%0d i=%0d a=%b",
                     name, out_valid, out_data, out_idx, out_any, ed, ei, ea);
        end
    endtask

    task automatic test_argmax;
        out_ready = 1'b1;
        run_one(pack5(3, 9, 9, 1, 7), 5'b11111, 8'd9, 3'd1, 1'b1, "all_mask");
        run_one(pack5(3, 9, 9, 1, 7), 5'b11101, 8'd9, 3'd2, 1'b1, "skip_op1");
        run_one(pack5(3, 9, 9, 1, 7), 5'b00000, 8'd0, 3'd0, 1'b0, "no_mask");
        run_one(pack5(3, 9, 9, 1, 7), 5'b10000, 8'd7, 3'd4, 1'b1, "only_op4");
        run_one(pack5(5, 5, 5, 5, 5), 5'b11111, 8'd5, 3'd0, 1'b1, "all_tie");
        run_one(pack5(200, 1, 2, 255, 254), 5'b11110, 8'd255, 3'd3, 1'b1, "max_255");
        run_one(pack5(0, 0, 0, 0, 0), 5'b00100, 8'd0, 3'd2, 1'b1, "zero_part");
    endtask

    task automatic test_back_to_back;
        logic [7:0] exp_d [4];
        logic [2:0] exp_i [4];
        logic [7:0] got_d [4];
        logic [2:0] got_i [4];
        int got;
        logic acc;
        exp_d = '{8'd5, 8'd20, 8'd8, 8'd200};
        exp_i = '{3'd4, 3'd1, 3'd2, 3'd4};
        got = 0;
        out_ready = 1'b1;
        in_valid = 1'b1;
        in_data = pack5(1, 2, 3, 4, 5);       in_mask = 5'b11111;
        tick;
        in_data = pack5(10, 20, 30, 40, 50);  in_mask = 5'b00011;
        tick;
        in_data = pack5(8, 8, 8, 8, 8);       in_mask = 5'b01100;
        tick;
        out_ready = 1'b0;
        in_data = pack5(0, 0, 0, 0, 200);     in_mask = 5'b11111;
        #1;
        n_cmp++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_ready_drop: got out_valid=%b in_ready=%b, want 1 0", out_valid, in_ready);
        end
        tick;
        tick;
        tick;
        n_cmp++;
        if (out_valid !== 1'b1 || out_data !== 8'd5 || out_idx !== 3'd4) begin
            n_err++;
            $display("FAIL b2b_hold: got v=%b d=%0d i=%0d, want v=1 d=5 i=4", out_valid, out_data, out_idx);
        end
        out_ready = 1'b1;
        #1;
        for (int c = 0; c < 20 && got < 4; c++) begin
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                got_d[got] = out_data;
                got_i[got] = out_idx;
                got++;
            end
            acc = in_valid && in_ready;
            tick;
            if (acc) in_valid = 1'b0;
        end
        n_cmp++;
        if (got != 4) begin
            n_err++;
            $display("FAIL b2b_count: got %0d outputs, want 4", got);
        end
        for (int i = 0; i < 4; i++) begin
            if (i < got) begin
                n_cmp++;
                if (got_d[i] !== exp_d[i] || got_i[i] !== exp_i[i]) begin
                    n_err++;
                    $display("FAIL b2b_order[%0d]: got d=%0d i=%0d, want d=%0d i=%0d",
                             i, got_d[i], got_i[i], exp_d[i], exp_i[i]);
                end
            end
        end
        tick;
        tick;
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_drain: out_valid=%b after drain, want 0", out_valid);
        end
    endtask

    task automatic test_reset_mid;
        logic seen;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = pack5(11, 12, 13, 14, 15); in_mask = 5'b11111;
        tick;
        in_data   = pack5(21, 22, 23, 24, 25); in_mask = 5'b11111;
        tick;
        rst = 1'b1;
        in_data   = pack5(31, 32, 33, 34, 35); in_mask = 5'b11111;
        tick;
        rst = 1'b0;
        in_valid = 1'b0;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL rst_mid_flush: got out_valid=%b in_ready=%b, want 0 1", out_valid, in_ready);
        end
        seen = 1'b0;
        for (int c = 0; c < 6; c++) begin
            tick;
            if (out_valid !== 1'b0) seen = 1'b1;
        end
        n_cmp++;
        if (seen !== 1'b0) begin
            n_err++;
            $display("FAIL rst_mid_ghost: out_valid seen=%b after reset, want 0", seen);
        end
    endtask

    task automatic test_single;
        out1_ready = 1'b1;
        in1_data   = 8'hA5;
        in1_mask   = 1'b1;
        in1_valid  = 1'b1;
        tick;
        in1_valid  = 1'b0;
        n_cmp++;
        if (out1_valid !== 1'b1 || out1_data !== 8'hA5 || out1_idx !== 1'b0 || out1_any !== 1'b1) begin
            n_err++;
            $display("FAIL single_mask1: got v=%b d=%h i=%0d a=%b, want v=1 d=a5 i=0 a=1",
                     out1_valid, out1_data, out1_idx, out1_any);
        end
        in1_mask  = 1'b0;
        in1_valid = 1'b1;
        tick;
        in1_valid = 1'b0;
        n_cmp++;
        if (out1_valid !== 1'b1 || out1_any !== 1'b0 || out1_idx !== 1'b0) begin
            n_err++;
            $display("FAIL single_mask0: got v=%b a=%b i=%0d, want v=1 a=0 i=0",
                     out1_valid, out1_any, out1_idx);
        end
        tick;
        n_cmp++;
        if (out1_valid !== 1'b0) begin
            n_err++;
            $display("FAIL single_drain: out1_valid=%b, want 0", out1_valid);
        end
    endtask

`ifdef TREE_ARGMAX_PIPE_PERF_CNT_EN
    task automatic test_perf;
        int pushed;
        logic acc;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        pushed = 0;
        for (int c = 0; c < 40; c++) begin
            out_ready = !(c >= 5 && c <= 8);
            in_valid  = (pushed < 10);
            in_data   = pack5(8'(pushed), 0, 0, 0, 0);
            in_mask   = 5'b00001;
            #1;
            acc = in_valid && in_ready;
            tick;
            if (acc) pushed++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        n_cmp++;
        if (perf_cnt !== 32'd10 || perf_stall !== 32'd4) begin
            n_err++;
            $display("FAIL perf_counts: got cnt=%0d stall=%0d, want cnt=10 stall=4", perf_cnt, perf_stall);
        end
        n_cmp++;
        if (perf1_cnt !== 32'd0 || perf1_stall !== 32'd0) begin
            n_err++;
            $display("FAIL perf_idle: got cnt=%0d stall=%0d, want 0 0", perf1_cnt, perf1_stall);
        end
    endtask
`endif

    initial begin
        test_reset;
        test_argmax;
        test_back_to_back;
        test_reset_mid;
        test_single;
`ifdef TREE_ARGMAX_PIPE_PERF_CNT_EN
        test_perf;
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/tree_argmax_pipe.md
Name: tree_argmax_pipe

Overview:
- Pipelined binary-tree argmax reduction over NumIn operands, one tree level per register stage.
- Nodes are laid out heap-style: level 0 is the root; node l of level k has index 2**k-1+l.
- Consumes the level/node generate structure produced by the parameter-elaboration stage.
- Serves as a sequential elaboration target: nested generate loops with localparams derived from $clog2.

Parameters:
- NumIn, 5, number of operands (>=1); need not be a power of two.
- DataWidth, 32, operand width, compared unsigned.
- Levels, derived localparam, (NumIn>1) ? $clog2(NumIn) : 1; equals the pipeline depth.
- IdxWidth, derived localparam, (NumIn>1) ? $clog2(NumIn) : 1.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous reset, active-high.
- in_valid_i  in  1  input vector valid.
- in_ready_o  out  1  input accepted when in_valid_i && in_ready_o.
- in_data_i  in  NumIn*DataWidth  operands; operand i at bits [i*DataWidth +: DataWidth].
- in_mask_i  in  NumIn  per-operand participate flag.
- out_valid_o  out  1  result valid.
- out_ready_i  in  1  downstream ready.
- out_data_o  out  DataWidth  maximum participating operand.
- out_idx_o  out  IdxWidth  index of that operand.
- out_any_o  out  1  at least one mask bit was set.

Behaviour:
- Leaf stage: 2**Levels leaves (heap index 2**Levels-1+l).
  - Leaf l < NumIn carries {mask[l], data[l], l}.
  - Padded leaves (l >= NumIn) are non-participating, data 0, index 0.
- Node rule: output = participating child with larger data. Ties and both-participating-equal go to the left (lower index) child. If only one child participates, output that child. If neither participates, output non-participating, data 0, index 0. Node participate = OR of children.
- Register layout: one register stage per level, Levels down to 1, each holding valid + 2**(k-1) nodes. The root register drives the outputs.
- Global enable: en = ~out_valid_o | out_ready_i.
  - in_ready_o = en, combinational; no internal bubble-collapsing.
  - When en, every stage loads from its predecessor. Stage Levels loads valid = in_valid_i.
  - When ~en, all stages hold.
- Latency: Levels cycles from accept to out_valid_o when unstalled. Throughput: 1 vector/cycle.
- Data and index registers load only when the incoming valid is 1. Bubbles keep stale payload, which must be unobservable because valid is 0.
- NumIn=1: single stage; out = {mask[0], data[0], 0}; latency 1.
- Reset values: all stage valid bits 0; out_data_o=0, out_idx_o=0, out_any_o=0; in_ready_o=1 in the first cycle after reset.
- Reset mid-operation: all in-flight vectors are discarded and no output handshake is generated for them. An input presented during a reset cycle is not accepted.
- Simultaneous output pop and input push in a full pipeline: allowed; no loss, order preserved.
- Ordering: strictly FIFO.

Optional Feature:
- Macro: TREE_ARGMAX_PIPE_PERF_CNT_EN.
- Defined:
  - Adds port perf_cnt_o (out, 32) counting output handshakes (out_valid_o && out_ready_i).
  - Counter wraps at 2**32; reset to 0 by rst_i.
  - Adds port perf_stall_o (out, 32) counting cycles with out_valid_o && ~out_ready_i, also wrapping.
- Undefined: neither port nor counter exists. Core behaviour is identical in both cases.

Decomposition:
- Package tree_argmax_pkg:
  - function tree_levels(n): the Levels formula.
  - function heap_idx(level, l) = 2**level-1+l.
  - perf counter width constant PerfCntWidth = 32.
- Sub-module tree_argmax_node:
  - Combinational two-child compare.
  - Parameters DataWidth, IdxWidth.
  - Ports: left/right {part, data, idx} in, merged {part, data, idx} out.
  - Instantiated inside nested generate loops over level and node.

Test Plan:
- NumIn=5, DataWidth=8, data=[3,9,9,1,7], mask=5'b11111, out_ready=1 -> after 3 cycles: out_valid=1, data=9, idx=1, any=1.
- Same data, mask=5'b11101 (operand 1 excluded) -> data=9, idx=2, any=1; mask=5'b00000 -> data=0, idx=0, any=0, out_valid still 1.
- Back-to-back inputs A, B, C, D with out_ready=0 from the cycle A reaches the output:
  - in_ready_o drops the same cycle.
  - Raising out_ready yields A, B, C, D in order, none lost or duplicated.
- Pipeline holding 2 vectors, rst_i pulsed one cycle -> next cycle out_valid_o=0 and in_ready_o=1; neither vector ever appears.
- NumIn=1, data=8'hA5, mask=1 -> out one cycle later: data=A5, idx=0, any=1; mask=0 -> any=0.
- With TREE_ARGMAX_PIPE_PERF_CNT_EN: 10 vectors with out_ready low for 4 cycles mid-stream -> perf_cnt_o=10, perf_stall_o=4. Preload to 32'hFFFFFFFF, one more handshake -> 0.
